// File: rtl/fifo_uart_tx_if.sv
// Read-port bundle between the 16-deep byte FIFO and its UART transmitter consumer.
// The transmitter is the master: it owns the read strobe, the FIFO answers with flag and data.
interface fifo_uart_tx_if;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_re;

  modport master (input fifo_empty, input fifo_data, output fifo_re);
  modport slave  (output fifo_empty, output fifo_data, input fifo_re);
endinterface

// File: rtl/fifo_uart_tx.sv
// FIFO read-side consumer: pops one byte at a time and sends it as UART 8N1, LSB first.
// Every output is registered from the next-state values so tx never glitches.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy,
  output logic           byte_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift_reg, shift_n;
  logic          tx_n, re_n, busy_n, done_n;
  logic [1:0]    rst_sync;
  logic          ready, start_ok, cnt_last;

  // Reset asserts at once but releases through two flops; IDLE holds until release is clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign ready    = rst_sync[1];
  assign start_ok = en && !fifo.fifo_empty && ready;
  assign cnt_last = (cnt == CNT_MAX);

  always_comb begin
    state_n   = state;
    cnt_n     = '0;
    bit_idx_n = bit_idx;
    shift_n   = shift_reg;
    case (state)
      IDLE:  if (start_ok) state_n = FETCH;
      FETCH: state_n = LOAD;
      LOAD: begin
        state_n = START;
        shift_n = fifo.fifo_data;
      end
      START: begin
        if (cnt_last) state_n = DATA;
        else          cnt_n   = cnt + 1'b1;
      end
      DATA: begin
        if (cnt_last) begin
          shift_n   = {1'b0, shift_reg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt_last) state_n = start_ok ? FETCH : IDLE;
        else          cnt_n   = cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase

    // Outputs are derived from where the FSM is heading so they change on the entering edge.
    tx_n = 1'b1;
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
    re_n   = (state_n == FETCH);
    busy_n = (state_n != IDLE);
    done_n = (state_n == STOP) && (cnt_n == CNT_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= 3'd0;
      shift_reg    <= 8'h00;
      tx           <= 1'b1;
      fifo.fifo_re <= 1'b0;
      busy         <= 1'b0;
      byte_done    <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      bit_idx      <= bit_idx_n;
      shift_reg    <= shift_n;
      tx           <= tx_n;
      fifo.fifo_re <= re_n;
      busy         <= busy_n;
      byte_done    <= done_n;
    end
  end

endmodule
